// File: rtl/agu.sv
// Address generation unit: one memory op at a time, IDLE -> CMD -> WB.
// Define AGU_MISALIGN_CHK_EN to trap misaligned H/W accesses instead of issuing them.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif

module agu (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   agu_i_valid,
  output logic                   agu_i_ready,
  input  logic [`XLEN-1:0]       agu_i_rs1,
  input  logic [`XLEN-1:0]       agu_i_rs2,
  input  logic [`XLEN-1:0]       agu_i_imm,
  input  logic                   agu_i_load,
  input  logic                   agu_i_store,
  input  logic                   agu_i_usign,
  input  logic [1:0]             agu_i_size,
  input  logic [4:0]             agu_i_rdidx,
  output logic                   agu_icb_cmd_valid,
  input  logic                   agu_icb_cmd_ready,
  output logic [`ADDR_SIZE-1:0]  agu_icb_cmd_addr,
  output logic                   agu_icb_cmd_read,
  output logic [`XLEN-1:0]       agu_icb_cmd_wdata,
  output logic [`XLEN/8-1:0]     agu_icb_cmd_wmask,
  input  logic [`XLEN-1:0]       agu_icb_rsp_rdata,
  output logic                   agu_o_valid,
  input  logic                   agu_o_ready,
  output logic [`XLEN-1:0]       agu_o_wbck_wdat,
  output logic [4:0]             agu_o_rdidx,
  output logic                   agu_o_wen,
  output logic                   agu_o_misalgn
);
  localparam int XLEN = `XLEN;
  localparam int AW   = `ADDR_SIZE;

  typedef enum logic [1:0] {IDLE, CMD, WB} state_t;
  state_t state, state_nxt;

  logic [XLEN-1:0] addr_r, rs2_r, wbck_r, acc_addr, shifted, ld_data;
  logic [1:0]      size_r;
  logic [4:0]      rdidx_r;
  logic            usign_r, ld_r, wen_r;
  logic            accept, acc_mem, acc_mis, skip_cmd, hs_cmd;
  logic [3:0]      mask_base;

  assign acc_addr = agu_i_rs1 + agu_i_imm;
  assign acc_mem  = agu_i_load | agu_i_store;
`ifdef AGU_MISALIGN_CHK_EN
  assign acc_mis  = acc_mem & (((agu_i_size == 2'd1) & acc_addr[0]) |
                               (agu_i_size[1] & (|acc_addr[1:0])));
`else
  assign acc_mis  = 1'b0;
`endif
  assign skip_cmd = ~acc_mem | acc_mis;
  assign accept   = agu_i_valid & agu_i_ready;
  assign hs_cmd   = agu_icb_cmd_valid & agu_icb_cmd_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = skip_cmd ? WB : CMD;
      CMD:     if (agu_icb_cmd_ready) state_nxt = WB;
      WB:      if (agu_o_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane-align the returned word, then extend from the access width.
  assign shifted = agu_icb_rsp_rdata >> {addr_r[1:0], 3'b000};
  always_comb begin
    case (size_r)
      2'd0:    ld_data = {{(XLEN-8){~usign_r & shifted[7]}}, shifted[7:0]};
      2'd1:    ld_data = {{(XLEN-16){~usign_r & shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_r  <= '0;
      rs2_r   <= '0;
      size_r  <= '0;
      usign_r <= 1'b0;
      ld_r    <= 1'b0;
      rdidx_r <= '0;
      wen_r   <= 1'b0;
      wbck_r  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_r  <= acc_addr;
        rs2_r   <= agu_i_rs2;
        size_r  <= agu_i_size;
        usign_r <= agu_i_usign;
        ld_r    <= agu_i_load & ~agu_i_store;
        rdidx_r <= agu_i_rdidx;
        wen_r   <= agu_i_load & ~agu_i_store & ~acc_mis;
        wbck_r  <= '0;
      end else if (hs_cmd && ld_r) begin
        wbck_r  <= ld_data;
      end
    end
  end

`ifdef AGU_MISALIGN_CHK_EN
  logic mis_r;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         mis_r <= 1'b0;
    else if (accept) mis_r <= acc_mis;
  end
  assign agu_o_misalgn = mis_r;
`else
  assign agu_o_misalgn = 1'b0;
`endif

  always_comb begin
    case (size_r)
      2'd0:    mask_base = 4'b0001;
      2'd1:    mask_base = 4'b0011;
      default: mask_base = 4'b1111;
    endcase
  end

  assign agu_i_ready       = (state == IDLE);
  assign agu_icb_cmd_valid = (state == CMD);
  assign agu_icb_cmd_addr  = {addr_r[AW-1:2], 2'b00};
  assign agu_icb_cmd_read  = ld_r;
  assign agu_icb_cmd_wdata = rs2_r << {addr_r[1:0], 3'b000};
  // Word stores always enable every lane; narrower ones shift and drop lanes past byte 3.
  assign agu_icb_cmd_wmask = ld_r ? 4'b0000 :
                             (size_r[1] ? 4'b1111 : (mask_base << addr_r[1:0]));
  assign agu_o_valid       = (state == WB);
  assign agu_o_wbck_wdat   = wbck_r;
  assign agu_o_rdidx       = rdidx_r;
  assign agu_o_wen         = wen_r;
endmodule

// File: tb/tb_agu.sv
// Bench for agu: directed vector table, reset corner sequences, and random ops
// checked against a byte-level reference model.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif

module tb_agu;
  logic        clk, rst;
  logic        agu_i_valid, agu_i_ready;
  logic [31:0] agu_i_rs1, agu_i_rs2, agu_i_imm;
  logic        agu_i_load, agu_i_store, agu_i_usign;
  logic [1:0]  agu_i_size;
  logic [4:0]  agu_i_rdidx;
  logic        agu_icb_cmd_valid, agu_icb_cmd_ready, agu_icb_cmd_read;
  logic [31:0] agu_icb_cmd_addr, agu_icb_cmd_wdata, agu_icb_rsp_rdata;
  logic [3:0]  agu_icb_cmd_wmask;
  logic        agu_o_valid, agu_o_ready, agu_o_wen, agu_o_misalgn;
  logic [31:0] agu_o_wbck_wdat;
  logic [4:0]  agu_o_rdidx;

  int n_chk = 0, n_pass = 0;

  agu dut (
    .clk(clk), .rst(rst),
    .agu_i_valid(agu_i_valid), .agu_i_ready(agu_i_ready),
    .agu_i_rs1(agu_i_rs1), .agu_i_rs2(agu_i_rs2), .agu_i_imm(agu_i_imm),
    .agu_i_load(agu_i_load), .agu_i_store(agu_i_store), .agu_i_usign(agu_i_usign),
    .agu_i_size(agu_i_size), .agu_i_rdidx(agu_i_rdidx),
    .agu_icb_cmd_valid(agu_icb_cmd_valid), .agu_icb_cmd_ready(agu_icb_cmd_ready),
    .agu_icb_cmd_addr(agu_icb_cmd_addr), .agu_icb_cmd_read(agu_icb_cmd_read),
    .agu_icb_cmd_wdata(agu_icb_cmd_wdata), .agu_icb_cmd_wmask(agu_icb_cmd_wmask),
    .agu_icb_rsp_rdata(agu_icb_rsp_rdata),
    .agu_o_valid(agu_o_valid), .agu_o_ready(agu_o_ready),
    .agu_o_wbck_wdat(agu_o_wbck_wdat), .agu_o_rdidx(agu_o_rdidx),
    .agu_o_wen(agu_o_wen), .agu_o_misalgn(agu_o_misalgn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs1, imm, rs2, rdata;
    logic        load, store, usign;
    logic [1:0]  size;
    logic [4:0]  rdidx;
    int          cstall, wstall;
    logic        exp_cmd;
    logic [31:0] exp_addr;
    logic        exp_read;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wdata, exp_wbck;
    logic        exp_wen, exp_mis;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(
    input logic [31:0] rs1, imm, rs2, rdata, input logic ld, st, us,
    input logic [1:0] sz, input logic [4:0] rd, input int cs, ws,
    input logic ecmd, input logic [31:0] eaddr, input logic erd,
    input logic [3:0] emask, input logic [31:0] ewd, ewb, input logic ewen, emis);
    vec_t v;
    v.rs1 = rs1; v.imm = imm; v.rs2 = rs2; v.rdata = rdata;
    v.load = ld; v.store = st; v.usign = us; v.size = sz; v.rdidx = rd;
    v.cstall = cs; v.wstall = ws;
    v.exp_cmd = ecmd; v.exp_addr = eaddr; v.exp_read = erd; v.exp_wmask = emask;
    v.exp_wdata = ewd; v.exp_wbck = ewb; v.exp_wen = ewen; v.exp_mis = emis;
    return v;
  endfunction

  // Byte-lane view of the access: which bytes it touches and what they carry.
  function automatic vec_t model(input vec_t vi);
    vec_t v = vi;
    logic [31:0] a;
    int off, n;
    logic ld, mem, mis;
    longint val;
    a   = v.rs1 + v.imm;
    off = int'(a[1:0]);
    n   = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    ld  = v.load && !v.store;
    mem = v.load || v.store;
    mis = 1'b0;
`ifdef AGU_MISALIGN_CHK_EN
    mis = mem && ((n == 2 && (off % 2) == 1) || (n == 4 && off != 0));
`endif
    v.exp_cmd  = mem && !mis;
    v.exp_mis  = mis;
    v.exp_addr = a & 32'hFFFF_FFFC;
    v.exp_read = ld;
    v.exp_wmask = 4'b0000;
    if (!ld) begin
      if (n == 4) v.exp_wmask = 4'b1111;
      else for (int b = 0; b < 4; b++) if (b >= off && b < off + n) v.exp_wmask[b] = 1'b1;
    end
    v.exp_wdata = 32'h0;
    for (int b = 0; b < 4; b++)
      if (b >= off) v.exp_wdata[8*b +: 8] = v.rs2[8*(b-off) +: 8];
    val = 0;
    if (ld && !mis) begin
      for (int k = 0; k < n; k++)
        if (off + k < 4) val += longint'(v.rdata[8*(off+k) +: 8]) << (8*k);
      if (!v.usign && n < 4 && val >= (longint'(1) << (8*n-1)))
        val -= (longint'(1) << (8*n));
    end
    v.exp_wbck = val[31:0];
    v.exp_wen  = ld && !mis;
    return v;
  endfunction

  task automatic scramble();
    agu_i_rs1 = $urandom; agu_i_rs2 = $urandom; agu_i_imm = $urandom;
    agu_i_load = 1'($urandom); agu_i_store = 1'($urandom); agu_i_usign = 1'($urandom);
    agu_i_size = 2'($urandom); agu_i_rdidx = 5'($urandom);
  endtask

  task automatic do_op(input vec_t v);
    @(negedge clk);
    chk("i_ready_idle", 32'(agu_i_ready), 32'd1);
    agu_i_rs1 = v.rs1; agu_i_rs2 = v.rs2; agu_i_imm = v.imm;
    agu_i_load = v.load; agu_i_store = v.store; agu_i_usign = v.usign;
    agu_i_size = v.size; agu_i_rdidx = v.rdidx; agu_i_valid = 1'b1;
    agu_icb_cmd_ready = 1'b0; agu_o_ready = 1'b0; agu_icb_rsp_rdata = $urandom;
    @(negedge clk);
    agu_i_valid = 1'b0;
    scramble();
    if (v.exp_cmd) begin
      for (int c = 0; c <= v.cstall; c++) begin
        chk("cmd_valid", 32'(agu_icb_cmd_valid), 32'd1);
        chk("cmd_addr", agu_icb_cmd_addr, v.exp_addr);
        chk("cmd_read", 32'(agu_icb_cmd_read), 32'(v.exp_read));
        chk("cmd_wmask", 32'(agu_icb_cmd_wmask), 32'(v.exp_wmask));
        chk("cmd_wdata", agu_icb_cmd_wdata, v.exp_wdata);
        chk("i_ready_cmd", 32'(agu_i_ready), 32'd0);
        chk("o_valid_cmd", 32'(agu_o_valid), 32'd0);
        if (c == v.cstall) begin
          agu_icb_cmd_ready = 1'b1;
          agu_icb_rsp_rdata = v.rdata;
        end
        @(negedge clk);
      end
      agu_icb_cmd_ready = 1'b0;
      agu_icb_rsp_rdata = $urandom;
    end
    for (int w = 0; w <= v.wstall; w++) begin
      chk("o_valid", 32'(agu_o_valid), 32'd1);
      chk("cmd_valid_wb", 32'(agu_icb_cmd_valid), 32'd0);
      chk("wbck_wdat", agu_o_wbck_wdat, v.exp_wbck);
      chk("rdidx", 32'(agu_o_rdidx), 32'(v.rdidx));
      chk("wen", 32'(agu_o_wen), 32'(v.exp_wen));
      chk("misalgn", 32'(agu_o_misalgn), 32'(v.exp_mis));
      chk("i_ready_wb", 32'(agu_i_ready), 32'd0);
      if (w == v.wstall) agu_o_ready = 1'b1;
      @(negedge clk);
    end
    agu_o_ready = 1'b0;
    chk("o_valid_done", 32'(agu_o_valid), 32'd0);
    chk("i_ready_done", 32'(agu_i_ready), 32'd1);
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    rst = 1'b1;
    agu_i_valid = 1'b0; agu_icb_cmd_ready = 1'b0; agu_o_ready = 1'b0;
    agu_icb_rsp_rdata = 32'h0;
    scramble();

    tbl[0] = mk(32'h8000_0000, 32'd3, 32'h0, 32'h80FF_0000, 1, 0, 0, 2'd0, 5'd5, 0, 0,
                1, 32'h8000_0000, 1, 4'b0000, 32'h0, 32'hFFFF_FF80, 1, 0);
    tbl[1] = mk(32'h8000_0010, 32'd2, 32'h1234_ABCD, 32'h0, 0, 1, 0, 2'd1, 5'd3, 3, 2,
                1, 32'h8000_0010, 0, 4'b1100, 32'hABCD_0000, 32'h0, 0, 0);
    tbl[2] = mk(32'h8000_0000, 32'd2, 32'h0, 32'h8001_0000, 1, 0, 1, 2'd1, 5'd9, 1, 1,
                1, 32'h8000_0000, 1, 4'b0000, 32'h0, 32'h0000_8001, 1, 0);
`ifdef AGU_MISALIGN_CHK_EN
    tbl[3] = mk(32'h8000_0000, 32'd1, 32'h0, 32'hDEAD_BEEF, 1, 0, 0, 2'd2, 5'd4, 0, 0,
                0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 0, 1);
`else
    tbl[3] = mk(32'h8000_0000, 32'd1, 32'h0, 32'hDEAD_BEEF, 1, 0, 0, 2'd2, 5'd4, 0, 0,
                1, 32'h8000_0000, 1, 4'b0000, 32'h0, 32'h00DE_ADBE, 1, 0);
`endif
    tbl[4] = mk(32'h1234_5678, 32'd1, 32'h0000_FFFF, 32'h0, 0, 0, 0, 2'd2, 5'd7, 0, 1,
                0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 0, 0);
    tbl[5] = mk(32'h0, 32'd1, 32'h55, 32'hFFFF_FFFF, 1, 1, 0, 2'd0, 5'd2, 1, 0,
                1, 32'h0, 0, 4'b0010, 32'h0000_5500, 32'h0, 0, 0);
    tbl[6] = mk(32'h100, 32'd0, 32'h0, 32'h0000_8123, 1, 0, 0, 2'd1, 5'd1, 0, 0,
                1, 32'h100, 1, 4'b0000, 32'h0, 32'hFFFF_8123, 1, 0);
    tbl[7] = mk(32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0000_AB00, 1, 0, 1, 2'd0, 5'd31, 0, 0,
                1, 32'h0, 1, 4'b0000, 32'h0, 32'h0000_00AB, 1, 0);
    tbl[8] = mk(32'h4, 32'd0, 32'hCAFE_F00D, 32'h0, 0, 1, 0, 2'd2, 5'd0, 2, 0,
                1, 32'h4, 0, 4'b1111, 32'hCAFE_F00D, 32'h0, 0, 0);

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_i_ready", 32'(agu_i_ready), 32'd1);
    chk("rst_cmd_valid", 32'(agu_icb_cmd_valid), 32'd0);
    chk("rst_o_valid", 32'(agu_o_valid), 32'd0);
    chk("rst_wbck", agu_o_wbck_wdat, 32'h0);
    chk("rst_rdidx", 32'(agu_o_rdidx), 32'd0);
    chk("rst_wen", 32'(agu_o_wen), 32'd0);
    chk("rst_misalgn", 32'(agu_o_misalgn), 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) do_op(tbl[i]);

    // Reset while a command is outstanding
    @(negedge clk);
    agu_i_rs1 = 32'h40; agu_i_imm = 32'h0; agu_i_load = 1'b1; agu_i_store = 1'b0;
    agu_i_size = 2'd2; agu_i_rdidx = 5'd12; agu_i_valid = 1'b1;
    @(negedge clk);
    agu_i_valid = 1'b0;
    chk("pre_rst_cmd_valid", 32'(agu_icb_cmd_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_cmd_drop", 32'(agu_icb_cmd_valid), 32'd0);
    chk("rst_cmd_i_ready", 32'(agu_i_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    agu_icb_cmd_ready = 1'b1; agu_o_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_cmd_no_wb", 32'(agu_o_valid), 32'd0);
      chk("rst_cmd_no_cmd", 32'(agu_icb_cmd_valid), 32'd0);
    end
    agu_icb_cmd_ready = 1'b0; agu_o_ready = 1'b0;

    // Reset during write-back
    @(negedge clk);
    agu_i_load = 1'b0; agu_i_store = 1'b0; agu_i_rdidx = 5'd21; agu_i_valid = 1'b1;
    @(negedge clk);
    agu_i_valid = 1'b0;
    chk("pre_rst_o_valid", 32'(agu_o_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_wb_drop", 32'(agu_o_valid), 32'd0);
    chk("rst_wb_rdidx", 32'(agu_o_rdidx), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      rv.rs1 = $urandom; rv.imm = $urandom_range(0, 15); rv.rs2 = $urandom;
      rv.rdata = $urandom; rv.load = 1'($urandom); rv.store = 1'($urandom);
      rv.usign = 1'($urandom); rv.size = 2'($urandom_range(0, 2));
      rv.rdidx = 5'($urandom); rv.cstall = $urandom_range(0, 2);
      rv.wstall = $urandom_range(0, 2);
      do_op(model(rv));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
